// File: rtl/div_err_monitor_if.sv
// ---------------------------------------------------------------------------
// div_err_monitor_if
// Groups the sample handshake, per-sample results and the running statistics
// of div_err_monitor.
//   master : drives in_valid, x, y, q_apx, r_apx, clr; observes everything else
//   slave  : the monitor itself
// Parameters CNT_W / ACC_W must match those given to div_err_monitor.
// ---------------------------------------------------------------------------
interface div_err_monitor_if #(
    parameter int CNT_W = 16,
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      x;
    logic [7:0]       y;
    logic [7:0]       q_apx;
    logic [7:0]       r_apx;
    logic             clr;
    logic             res_valid;
    logic [7:0]       q_exact;
    logic [7:0]       r_exact;
    logic [7:0]       err_dist;
    logic             err_flag;
    logic             ovf;
    logic [CNT_W-1:0] samples;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] ovf_count;
    logic [ACC_W-1:0] err_sum;
    logic [7:0]       err_max;

    modport master (
        output in_valid, x, y, q_apx, r_apx, clr,
        input  in_ready, res_valid, q_exact, r_exact, err_dist, err_flag, ovf,
        input  samples, err_count, ovf_count, err_sum, err_max
    );

    modport slave (
        input  in_valid, x, y, q_apx, r_apx, clr,
        output in_ready, res_valid, q_exact, r_exact, err_dist, err_flag, ovf,
        output samples, err_count, ovf_count, err_sum, err_max
    );
endinterface

// File: rtl/div_err_monitor.sv
// ---------------------------------------------------------------------------
// div_err_monitor
// Checker for a 16/8 array divider (exact or approximate). Each accepted
// sample (x, y, q_apx, r_apx) is re-divided with an 8-step restoring divider;
// the exact quotient/remainder, the quotient error distance and an error flag
// are reported with a one-cycle res_valid pulse, and saturating running
// statistics are kept for characterisation runs.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous reset, active-low (clears FSM, outputs, statistics)
//   bus    : div_err_monitor_if.slave
//            in_valid/in_ready  sample handshake (ready only while idle)
//            x, y, q_apx, r_apx operands and divider-under-test results
//            clr                synchronous clear of statistics
//            res_valid, q_exact, r_exact, err_dist, err_flag, ovf
//            samples, err_count, ovf_count, err_sum, err_max
// ---------------------------------------------------------------------------
module div_err_monitor #(
    parameter int CNT_W = 16,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    div_err_monitor_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [2:0]       cnt;
    logic [7:0]       rem;
    logic [7:0]       qacc;
    logic [7:0]       x_lo;
    logic [7:0]       y_r;
    logic [7:0]       q_apx_r;
    logic [7:0]       r_apx_r;

    logic [7:0]       q_exact_r;
    logic [7:0]       r_exact_r;
    logic [7:0]       err_dist_r;
    logic             err_flag_r;
    logic             ovf_r;

    logic [CNT_W-1:0] samples_r;
    logic [CNT_W-1:0] err_count_r;
    logic [CNT_W-1:0] ovf_count_r;
    logic [ACC_W-1:0] err_sum_r;
    logic [7:0]       err_max_r;

    logic             ovf_in;
    logic [8:0]       t;
    logic             ge;
    logic [7:0]       rem_nxt;
    logic [7:0]       q_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [7:0] d);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W-7){1'b0}}, d};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[8] ? 8'(-d) : d[7:0];
    endfunction

    // The quotient only fits in 8 bits when the high dividend byte is below y.
    assign ovf_in = (bus.y == 8'd0) || (bus.x[15:8] >= bus.y);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        t       = {rem, x_lo[cnt]};
        ge      = (t >= {1'b0, y_r});
        rem_nxt = t[7:0];
        if (ge)
            rem_nxt = 8'(t - {1'b0, y_r});
        q_nxt      = qacc;
        q_nxt[cnt] = ge;
    end

    // FSM, divider datapath and per-sample result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            rem        <= 8'd0;
            qacc       <= 8'd0;
            x_lo       <= 8'd0;
            y_r        <= 8'd0;
            q_apx_r    <= 8'd0;
            r_apx_r    <= 8'd0;
            q_exact_r  <= 8'd0;
            r_exact_r  <= 8'd0;
            err_dist_r <= 8'd0;
            err_flag_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_lo    <= bus.x[7:0];
                        y_r     <= bus.y;
                        q_apx_r <= bus.q_apx;
                        r_apx_r <= bus.r_apx;
                        if (ovf_in) begin
                            state      <= DONE;
                            q_exact_r  <= 8'd0;
                            r_exact_r  <= 8'd0;
                            err_dist_r <= 8'd0;
                            err_flag_r <= 1'b0;
                            ovf_r      <= 1'b1;
                        end else begin
                            state <= CALC;
                            rem   <= bus.x[15:8];
                            qacc  <= 8'd0;
                            cnt   <= 3'd7;
                        end
                    end
                end
                CALC: begin
                    rem  <= rem_nxt;
                    qacc <= q_nxt;
                    cnt  <= cnt - 3'd1;
                    // Results are registered on the way into DONE so they
                    // stay stable until the next sample completes.
                    if (cnt == 3'd0) begin
                        state      <= DONE;
                        q_exact_r  <= q_nxt;
                        r_exact_r  <= rem_nxt;
                        err_dist_r <= abs_diff(q_apx_r, q_nxt);
                        err_flag_r <= (q_apx_r != q_nxt) || (r_apx_r != rem_nxt);
                        ovf_r      <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Statistics: accumulated at the end of DONE; clr takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr) begin
            samples_r   <= '0;
            err_count_r <= '0;
            ovf_count_r <= '0;
            err_sum_r   <= '0;
            err_max_r   <= 8'd0;
        end else if (state == DONE) begin
            if (ovf_r) begin
                ovf_count_r <= sat_inc(ovf_count_r, 1'b1);
            end else begin
                samples_r   <= sat_inc(samples_r, 1'b1);
                err_count_r <= sat_inc(err_count_r, err_flag_r);
                err_sum_r   <= sat_add(err_sum_r, err_dist_r);
                if (err_dist_r > err_max_r)
                    err_max_r <= err_dist_r;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.res_valid = (state == DONE);
    assign bus.q_exact   = q_exact_r;
    assign bus.r_exact   = r_exact_r;
    assign bus.err_dist  = err_dist_r;
    assign bus.err_flag  = err_flag_r;
    assign bus.ovf       = ovf_r;
    assign bus.samples   = samples_r;
    assign bus.err_count = err_count_r;
    assign bus.ovf_count = ovf_count_r;
    assign bus.err_sum   = err_sum_r;
    assign bus.err_max   = err_max_r;

endmodule

// File: tb/tb_div_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_div_err_monitor
// Scoreboard bench for div_err_monitor. Narrow counters (CNT_W=4) and a
// narrow accumulator (ACC_W=10) make the saturation behaviour reachable.
// ---------------------------------------------------------------------------
module tb_div_err_monitor;
    localparam int CW   = 4;
    localparam int AW   = 10;
    localparam int CMAX = (1 << CW) - 1;
    localparam int AMAX = (1 << AW) - 1;
    localparam int SW   = 3 * CW + AW + 8;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic [7:0] d;
        logic       f;
        logic       o;
        logic       rdy;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    res_t exp_q[$];
    res_t obs_q[$];
    int   obs_cyc[$];

    // reference statistics
    int ms, me, mo, msum, mmax;

    div_err_monitor_if #(.CNT_W(CW), .ACC_W(AW)) bus ();

    div_err_monitor #(.CNT_W(CW), .ACC_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.res_valid === 1'b1) begin
            obs_q.push_back({bus.q_exact, bus.r_exact, bus.err_dist, bus.err_flag, bus.ovf, bus.in_ready});
            obs_cyc.push_back(cyc);
        end
    end

    function automatic logic [SW-1:0] stats_act();
        return {bus.samples, bus.err_count, bus.ovf_count, bus.err_sum, bus.err_max};
    endfunction

    function automatic logic [SW-1:0] stats_exp();
        return {CW'(ms), CW'(me), CW'(mo), AW'(msum), 8'(mmax)};
    endfunction

    task automatic model_clear();
        ms = 0; me = 0; mo = 0; msum = 0; mmax = 0;
    endtask

    task automatic model_push(input logic [15:0] xv, input logic [7:0] yv,
                              input logic [7:0] qv, input logic [7:0] rv);
        res_t e;
        int   qe, re, d;
        e = '0;
        if (yv == 8'd0 || int'(xv[15:8]) >= int'(yv)) begin
            e.o = 1'b1;
            if (mo < CMAX) mo++;
        end else begin
            qe  = int'(xv) / int'(yv);
            re  = int'(xv) % int'(yv);
            d   = (int'(qv) > qe) ? int'(qv) - qe : qe - int'(qv);
            e.q = 8'(qe);
            e.r = 8'(re);
            e.d = 8'(d);
            e.f = (int'(qv) != qe) || (int'(rv) != re);
            if (ms < CMAX) ms++;
            if (e.f && me < CMAX) me++;
            msum = (msum + d > AMAX) ? AMAX : msum + d;
            if (d > mmax) mmax = d;
        end
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [15:0] xv, input logic [7:0] yv,
                        input logic [7:0] qv, input logic [7:0] rv, output int a);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
        bus.x = xv; bus.y = yv; bus.q_apx = qv; bus.r_apx = rv;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        a = cyc;
        bus.in_valid = 1'b0;
        model_push(xv, yv, qv, rv);
    endtask

    task automatic wait_obs(input int n);
        int k = 0;
        while (obs_q.size() < n && k < 40) begin
            @(posedge clk); #2;
            k++;
        end
    endtask

    task automatic pop_pair(output res_t o, output res_t e, output int oc, output bit ok);
        ok = (obs_q.size() > 0) && (exp_q.size() > 0);
        o = '0; e = '0; oc = -1;
        if (ok) begin
            o  = obs_q.pop_front();
            e  = exp_q.pop_front();
            oc = obs_cyc.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.x = 16'd199; bus.y = 8'd7;
        bus.q_apx = 8'd28; bus.r_apx = 8'd3; bus.clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b res_valid=%b, required 1 0", bus.in_ready, bus.res_valid);
        end
        checks++;
        if ({bus.q_exact, bus.r_exact, bus.err_dist, bus.err_flag, bus.ovf} !== 26'd0) begin
            errors++;
            $display("FAIL reset_res: got %h, required 0",
                     {bus.q_exact, bus.r_exact, bus.err_dist, bus.err_flag, bus.ovf});
        end
        checks++;
        if (stats_act() !== stats_exp()) begin
            errors++;
            $display("FAIL reset_stats: got %h, required %h", stats_act(), stats_exp());
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_nopulse: %0d res_valid pulses, required 0", obs_q.size());
        end
    endtask

    task automatic test_exact();
        res_t o, e; int a, oc; bit ok;
        send(16'd199, 8'd7, 8'd28, 8'd3, a);
        wait_obs(1);
        pop_pair(o, e, oc, ok);
        checks++;
        if (!ok || o !== e) begin
            errors++;
            $display("FAIL exact_result: got %h, required %h (present=%0b)", o, e, ok);
        end
        checks++;
        if (oc != a + 8) begin
            errors++;
            $display("FAIL exact_latency: res_valid at %0d, required %0d", oc, a + 8);
        end
        checks++;
        if (stats_act() !== stats_exp()) begin
            errors++;
            $display("FAIL exact_stats: got %h, required %h", stats_act(), stats_exp());
        end
    endtask

    task automatic test_error();
        res_t o, e; int a, oc; bit ok;
        send(16'd40, 8'd13, 8'd2, 8'd14, a);
        wait_obs(1);
        pop_pair(o, e, oc, ok);
        checks++;
        if (!ok || o !== e) begin
            errors++;
            $display("FAIL error_result: got %h, required %h (present=%0b)", o, e, ok);
        end
        checks++;
        if (stats_act() !== stats_exp()) begin
            errors++;
            $display("FAIL error_stats: got %h, required %h", stats_act(), stats_exp());
        end
    endtask

    task automatic test_ovf();
        res_t o, e; int a, oc; bit ok;
        logic [15:0] xs [2];
        logic [7:0]  ys [2];
        xs[0] = 16'd300;   ys[0] = 8'd0;
        xs[1] = 16'h0800;  ys[1] = 8'd8;
        for (int i = 0; i < 2; i++) begin
            send(xs[i], ys[i], 8'd5, 8'd5, a);
            wait_obs(1);
            checks++;
            if (bus.in_ready !== 1'b1 || cyc != a + 1) begin
                errors++;
                $display("FAIL ovf_ready%0d: in_ready=%b at cycle %0d, required 1 at %0d",
                         i, bus.in_ready, cyc, a + 1);
            end
            pop_pair(o, e, oc, ok);
            checks++;
            if (!ok || o !== e) begin
                errors++;
                $display("FAIL ovf_result%0d: got %h, required %h (present=%0b)", i, o, e, ok);
            end
            checks++;
            if (oc != a) begin
                errors++;
                $display("FAIL ovf_latency%0d: res_valid at %0d, required %0d", i, oc, a);
            end
        end
        checks++;
        if (stats_act() !== stats_exp()) begin
            errors++;
            $display("FAIL ovf_stats: got %h, required %h", stats_act(), stats_exp());
        end
    endtask

    task automatic test_back_to_back();
        res_t o, e; int oc, prev; bit ok, rdy;
        int k = 0;
        int iters = 0;
        logic [15:0] xs [5];
        logic [7:0]  ys [5], qs [5], rs [5];
        xs[0] = 16'd1000;  ys[0] = 8'd9;   qs[0] = 8'd111; rs[0] = 8'd1;
        xs[1] = 16'd5000;  ys[1] = 8'd50;  qs[1] = 8'd100; rs[1] = 8'd0;
        xs[2] = 16'd255;   ys[2] = 8'd1;   qs[2] = 8'd0;   rs[2] = 8'd0;
        xs[3] = 16'd30000; ys[3] = 8'd200; qs[3] = 8'd148; rs[3] = 8'd0;
        xs[4] = 16'd12345; ys[4] = 8'd99;  qs[4] = 8'd124; rs[4] = 8'd70;
        bus.x = xs[0]; bus.y = ys[0]; bus.q_apx = qs[0]; bus.r_apx = rs[0];
        bus.in_valid = 1'b1;
        for (int c = 0; c < 100 && k < 5; c++) begin
            rdy = bus.in_ready;
            @(posedge clk); #1;
            iters++;
            if (rdy) begin
                model_push(xs[k], ys[k], qs[k], rs[k]);
                k++;
                if (k < 5) begin
                    bus.x = xs[k]; bus.y = ys[k]; bus.q_apx = qs[k]; bus.r_apx = rs[k];
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (iters != 41) begin
            errors++;
            $display("FAIL b2b_accept: 5 accepts took %0d cycles, required 41", iters);
        end
        wait_obs(5);
        checks++;
        if (obs_q.size() != 5) begin
            errors++;
            $display("FAIL b2b_count: %0d res_valid pulses, required 5", obs_q.size());
        end
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            pop_pair(o, e, oc, ok);
            checks++;
            if (!ok || o !== e) begin
                errors++;
                $display("FAIL b2b_result%0d: got %h, required %h (present=%0b)", i, o, e, ok);
            end
            if (i > 0) begin
                checks++;
                if (oc - prev != 10) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: %0d cycles between pulses, required 10", i, oc - prev);
                end
            end
            prev = oc;
        end
        checks++;
        if (stats_act() !== stats_exp()) begin
            errors++;
            $display("FAIL b2b_stats: got %h, required %h", stats_act(), stats_exp());
        end
    endtask

    task automatic test_reset_abort();
        res_t o, e, dummy; int a, oc; bit ok;
        send(16'd1000, 8'd9, 8'd111, 8'd1, a);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dummy = exp_q.pop_back();
        model_clear();
        checks++;
        if (bus.in_ready !== 1'b1 || stats_act() !== stats_exp()) begin
            errors++;
            $display("FAIL abort_reset: in_ready=%b stats=%h, required 1 %h",
                     bus.in_ready, stats_act(), stats_exp());
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL abort_nopulse: %0d res_valid pulses, required 0", obs_q.size());
        end
        send(16'd127, 8'd5, 8'd25, 8'd2, a);
        wait_obs(1);
        pop_pair(o, e, oc, ok);
        checks++;
        if (!ok || o !== e) begin
            errors++;
            $display("FAIL abort_result: got %h, required %h (present=%0b)", o, e, ok);
        end
        checks++;
        if (stats_act() !== stats_exp()) begin
            errors++;
            $display("FAIL abort_stats: got %h, required %h", stats_act(), stats_exp());
        end
    endtask

    task automatic test_saturation();
        res_t o, e; int a, oc; bit ok;
        for (int i = 0; i < 16; i++) begin
            send(16'd1000, 8'd9, 8'd11, 8'd1, a);
            wait_obs(1);
            pop_pair(o, e, oc, ok);
            checks++;
            if (!ok || o !== e) begin
                errors++;
                $display("FAIL sat_result%0d: got %h, required %h (present=%0b)", i, o, e, ok);
            end
        end
        for (int i = 0; i < 16; i++) begin
            send(16'hFF00, 8'h10, 8'd0, 8'd0, a);
            wait_obs(1);
            pop_pair(o, e, oc, ok);
        end
        checks++;
        if (stats_act() !== stats_exp()) begin
            errors++;
            $display("FAIL sat_stats: got %h, required %h", stats_act(), stats_exp());
        end
        // clr raised exactly in the DONE cycle of a fresh sample
        send(16'd1000, 8'd9, 8'd111, 8'd1, a);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (bus.res_valid !== 1'b1) begin
            errors++;
            $display("FAIL clr_done: res_valid=%b at cycle %0d, required 1", bus.res_valid, cyc);
        end
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        model_clear();
        checks++;
        if (stats_act() !== stats_exp()) begin
            errors++;
            $display("FAIL clr_stats: got %h, required %h", stats_act(), stats_exp());
        end
        wait_obs(1);
        pop_pair(o, e, oc, ok);
        checks++;
        if (!ok || o !== e || bus.q_exact !== e.q || bus.r_exact !== e.r) begin
            errors++;
            $display("FAIL clr_result: got %h q=%0d r=%0d, required %h", o, bus.q_exact, bus.r_exact, e);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.x = 16'd0; bus.y = 8'd0; bus.q_apx = 8'd0; bus.r_apx = 8'd0;
        bus.clr = 1'b0;
        model_clear();
        test_reset();
        test_exact();
        test_error();
        test_ovf();
        test_back_to_back();
        test_reset_abort();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
